// File: rtl/float_mult_fp16.sv
// float_mult_fp16: two-stage binary16 multiplier, flush-to-zero on subnormal
// inputs and outputs, round-to-nearest-even, canonical quiet NaN 16'h7E00.
// Stage 1 classifies the operands and forms the 22-bit significand product.
// Stage 2 normalizes, rounds, range-checks and registers the result.
module float_mult_fp16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic        out_valid,
    output logic [15:0] product
);

    typedef struct packed {
        logic               sign;
        logic               nan;   // any NaN operand, or Inf x 0
        logic               inf;   // at least one Inf operand
        logic               zero;  // at least one zero/subnormal operand
        logic signed [7:0]  exp;   // eA + eB - 15, unnormalized
        logic [21:0]        prod;  // {1,fracA} * {1,fracB}
    } stage1T;

    // valid shift register: bit 0 = stage 1 occupied, bit 1 = output valid
    logic [1:0] vldPipe;
    stage1T     s1Next, s1;

    // ---------------- stage 1: classify and multiply ----------------
    logic [4:0]  expA, expB;
    logic [9:0]  fracA, fracB;
    logic        zeroA, zeroB, infA, infB, nanA, nanB;

    assign expA  = floatA[14:10];
    assign expB  = floatB[14:10];
    assign fracA = floatA[9:0];
    assign fracB = floatB[9:0];
    assign zeroA = (expA == 5'd0);
    assign zeroB = (expB == 5'd0);
    assign infA  = (expA == 5'd31) && (fracA == 10'd0);
    assign infB  = (expB == 5'd31) && (fracB == 10'd0);
    assign nanA  = (expA == 5'd31) && (fracA != 10'd0);
    assign nanB  = (expB == 5'd31) && (fracB != 10'd0);

    // operand classification and raw product for the stage 1 register
    always_comb begin
        s1Next      = '0;
        s1Next.sign = floatA[15] ^ floatB[15];
        s1Next.nan  = nanA | nanB | ((infA | infB) & (zeroA | zeroB));
        s1Next.inf  = infA | infB;
        s1Next.zero = zeroA | zeroB;
        s1Next.exp  = $signed({3'b000, expA}) + $signed({3'b000, expB}) - 8'sd15;
        s1Next.prod = 22'({1'b1, fracA}) * 22'({1'b1, fracB});
    end

    // ---------------- stage 2: normalize, round, pack ----------------
    logic               hi, guard, sticky, roundUp, carry;
    logic [9:0]         fracKeep, fracRnd;
    logic signed [7:0]  expFinal;
    logic [15:0]        result;

    // product in [1,4): bit 21 set means the value is >= 2 and shifts right once
    always_comb begin
        hi       = s1.prod[21];
        fracKeep = hi ? s1.prod[20:11] : s1.prod[19:10];
        guard    = hi ? s1.prod[10]    : s1.prod[9];
        sticky   = hi ? (|s1.prod[9:0]) : (|s1.prod[8:0]);
        roundUp  = guard & (sticky | fracKeep[0]);
        // a carry out of the fraction means 1.11..1 rounded to 10.0; the
        // wrapped fraction is already zero, only the exponent bumps
        {carry, fracRnd} = {1'b0, fracKeep} + {10'd0, roundUp};
        expFinal = s1.exp + $signed({7'd0, hi}) + $signed({7'd0, carry});
    end

    // special-case priority, then overflow/underflow range check
    always_comb begin
        result = '0;
        if (s1.nan)
            result = 16'h7E00;
        else if (s1.inf)
            result = {s1.sign, 5'h1F, 10'h000};
        else if (s1.zero)
            result = {s1.sign, 15'h0000};
        else if (expFinal >= 8'sd31)
            result = {s1.sign, 5'h1F, 10'h000};
        else if (expFinal <= 8'sd0)
            result = {s1.sign, 15'h0000};
        else
            result = {s1.sign, expFinal[4:0], fracRnd};
    end

    // pipeline registers; product only updates when a valid result arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vldPipe <= '0;
            s1      <= '0;
            product <= 16'h0000;
        end else begin
            vldPipe <= {vldPipe[0], in_valid};
            if (in_valid)
                s1 <= s1Next;
            if (vldPipe[0])
                product <= result;
        end
    end

    assign out_valid = vldPipe[1];

endmodule

// File: tb/tb_float_mult_fp16.sv
// Self-checking bench for float_mult_fp16: directed vectors plus random
// operands checked against a real-number reference model.
module tb_float_mult_fp16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] floatA, floatB;
    logic        out_valid;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    logic [15:0] expQ[$];
    logic        lastV = 1'b0;
    logic [15:0] held  = 16'h0000;

    always #5 clk = ~clk;

    float_mult_fp16 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .floatA(floatA), .floatB(floatB),
        .out_valid(out_valid), .product(product)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    // reference: exact product in real arithmetic, then RNE to binary16
    function automatic logic [15:0] refMul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        logic aZ, bZ, aI, bI, aN, bN;
        real  x, m, scaled, rem;
        int   e, ip, be;
        s  = a[15] ^ b[15];
        aZ = (a[14:10] == 5'd0);
        bZ = (b[14:10] == 5'd0);
        aI = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
        bI = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
        aN = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
        bN = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
        if (aN || bN || ((aI || bI) && (aZ || bZ))) return 16'h7E00;
        if (aI || bI) return {s, 5'h1F, 10'h000};
        if (aZ || bZ) return {s, 15'h0000};
        x = (real'(1024 + int'(a[9:0])) / 1024.0) * pow2(int'(a[14:10]) - 15)
          * (real'(1024 + int'(b[9:0])) / 1024.0) * pow2(int'(b[14:10]) - 15);
        m = x;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        scaled = m * 1024.0;
        ip  = $rtoi(scaled);
        rem = scaled - real'(ip);
        if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
        if (ip == 2048) begin ip = 1024; e++; end
        be = e + 15;
        if (be >= 31) return {s, 5'h1F, 10'h000};
        if (be <= 0)  return {s, 15'h0000};
        return {s, be[4:0], ip[9:0]};
    endfunction

    function automatic logic [15:0] rndOp();
        int         c;
        logic [4:0] e;
        logic [9:0] f;
        c = int'($urandom_range(0, 15));
        f = 10'($urandom);
        if (c == 0)      e = 5'd0;
        else if (c == 1) begin e = 5'd31; if ($urandom_range(0, 1) == 0) f = 10'd0; end
        else if (c < 5)  e = 5'($urandom_range(1, 30));
        else             e = 5'($urandom_range(8, 22));
        return {1'($urandom), e, f};
    endfunction

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e);
        @(negedge clk);
        in_valid = v;
        floatA   = a;
        floatB   = b;
        if (v && rst_n) expQ.push_back(e);
    endtask

    // output monitor: result of the operand sampled on the previous edge
    always @(posedge clk) begin
        logic        pV;
        logic [15:0] pE;
        if (!rst_n) begin
            expQ.delete();
            lastV = 1'b0;
            held  = 16'h0000;
        end else begin
            pV    = lastV;
            lastV = in_valid;
            pE    = held;
            if (pV) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL queue: got empty expected entry");
                end else begin
                    pE = expQ.pop_front();
                end
            end
            #1;
            chk("outValid", {15'd0, out_valid}, {15'd0, pV});
            chk(pV ? "product" : "hold", product, pE);
            held = pE;
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        floatA   = 16'h39D2;
        floatB   = 16'h35A1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstProduct", product, 16'h0000);
        chk("rstValid", {15'd0, out_valid}, 16'h0000);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // single op, then idle: out_valid must rise exactly two cycles later
        drive(1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);

        // back-to-back stream
        drive(1'b1, 16'h39D2, 16'h35A1, 16'h3418);
        drive(1'b1, 16'h35A1, 16'h0000, 16'h0000);
        drive(1'b1, 16'h0000, 16'h39D2, 16'h0000);
        drive(1'b1, 16'hD0A4, 16'h4BD6, 16'hE08C);
        drive(1'b0, 16'h1234, 16'h4321, 16'h0000);
        drive(1'b0, 16'h1234, 16'h4321, 16'h0000);

        // signed zero and specials
        drive(1'b1, 16'h8000, 16'h3C00, 16'h8000);
        drive(1'b1, 16'h7C00, 16'h0000, 16'h7E00);
        drive(1'b1, 16'hFC00, 16'h4000, 16'hFC00);
        drive(1'b1, 16'h7BFF, 16'h4000, 16'h7C00);
        drive(1'b1, 16'h0400, 16'h3800, 16'h0000);
        drive(1'b1, 16'h7E01, 16'h3C00, 16'h7E00);
        drive(1'b1, 16'h3C00, 16'hFC01, 16'h7E00);
        drive(1'b1, 16'h7D00, 16'h0000, 16'h7E00);
        drive(1'b1, 16'h7C00, 16'hFC00, 16'hFC00);
        drive(1'b1, 16'h0000, 16'h8000, 16'h8000);
        drive(1'b1, 16'h03FF, 16'h7BFF, 16'h0000);
        drive(1'b1, 16'hBC00, 16'h3C00, 16'hBC00);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);

        // asynchronous reset with operations in flight
        drive(1'b1, 16'h4000, 16'h4000, 16'h4400);
        drive(1'b1, 16'h4200, 16'h4000, 16'h4600);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("asyncRstProduct", product, 16'h0000);
        chk("asyncRstValid", {15'd0, out_valid}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);

        // random operands, random valid gaps
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a, b;
            logic        v;
            a = rndOp();
            b = rndOp();
            v = ($urandom_range(0, 3) != 0);
            drive(v, a, b, refMul(a, b));
        end
        repeat (4) drive(1'b0, 16'h0000, 16'h0000, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
